mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
// -----------------------------------------------------------------------------
// Two-port arbiter in front of a single shared 32-bit memory.
//   Port 0 is an instruction-fetch port that issues word reads only.
//   Port 1 is a load/store port that issues byte, half and word accesses.
// The memory read is combinational and its write is byte-masked on the rising
// edge. Grants are combinational. Every granted access returns a response one
// cycle later, so either port can be granted on every cycle with no bubbles.
//
// Ports
//   i_clk, i_reset              clock, synchronous active-high reset
//   i_p0_req, i_p0_addr         port 0 request and byte address
//   o_p0_gnt                    port 0 grant (same cycle as the request)
//   o_p0_rvalid, o_p0_rdata     port 0 read response (one cycle after grant)
//   i_p1_req, i_p1_addr         port 1 request and byte address
//   i_p1_wren                   port 1 store (1) or load (0)
//   i_p1_size                   00 byte, 01 half, 10 word, 11 illegal
//   i_p1_unsigned               zero-extend (1) or sign-extend (0) sub-word loads
//   i_p1_wdata                  store data, already lane-aligned by the requester
//   o_p1_gnt                    port 1 grant
//   o_p1_rvalid, o_p1_rdata     port 1 response (load data, or 0 for store ack)
//   o_p1_err                    misaligned or illegal-size access, with rvalid
//   o_mem_addr, o_mem_bmask     shared memory address and byte-lane enables
//   o_mem_wdata, o_mem_wren     shared memory write data and write enable
//   i_mem_rdata                 shared memory combinational read data
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int AW = 8
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_p0_req,
  input  logic [AW-1:0] i_p0_addr,
  output logic          o_p0_gnt,
  output logic          o_p0_rvalid,
  output logic [31:0]   o_p0_rdata,
  input  logic          i_p1_req,
  input  logic [AW-1:0] i_p1_addr,
  input  logic          i_p1_wren,
  input  logic [1:0]    i_p1_size,
  input  logic          i_p1_unsigned,
  input  logic [31:0]   i_p1_wdata,
  output logic          o_p1_gnt,
  output logic          o_p1_rvalid,
  output logic [31:0]   o_p1_rdata,
  output logic          o_p1_err,
  output logic [AW-1:0] o_mem_addr,
  output logic [3:0]    o_mem_bmask,
  output logic [31:0]   o_mem_wdata,
  output logic          o_mem_wren,
  input  logic [31:0]   i_mem_rdata
);

  // Access is illegal when it is not naturally aligned or when the size code is 11.
  function automatic logic access_error(input logic [1:0] size, input logic [1:0] lsb);
    logic err;
    case (size)
      2'b00:   err = 1'b0;
      2'b01:   err = lsb[0];
      2'b10:   err = (lsb != 2'b00);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

  // Store data arrives lane-aligned, so the mask always starts at lane 0.
  function automatic logic [3:0] size_mask(input logic [1:0] size);
    logic [3:0] mask;
    case (size)
      2'b00:   mask = 4'b0001;
      2'b01:   mask = 4'b0011;
      2'b10:   mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

  // Reduces a memory word to the requested load width and extends it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [1:0]  size,
                                               input logic        is_unsigned,
                                               input logic [31:0] word);
    logic [31:0] res;
    case (size)
      2'b00:   res = is_unsigned ? {24'h000000, word[7:0]}
                                 : {{24{word[7]}}, word[7:0]};
      2'b01:   res = is_unsigned ? {16'h0000, word[15:0]}
                                 : {{16{word[15]}}, word[15:0]};
      default: res = word;
    endcase
    return res;
  endfunction

  // pri_r names the port that wins the next contended cycle (1 = port 1).
  logic        pri_r;
  logic        gnt0_s;
  logic        gnt1_s;
  logic        p1_err_s;
  logic [31:0] p1_resp_s;

  logic        p0_rvalid_r;
  logic [31:0] p0_rdata_r;
  logic        p1_rvalid_r;
  logic        p1_err_r;
  logic [31:0] p1_rdata_r;

  assign p1_err_s = access_error(i_p1_size, i_p1_addr[1:0]);

  // Grant decision: a lone requester always wins; contention goes to pri_r.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (i_reset) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else if (i_p0_req && i_p1_req) begin
      gnt0_s = ~pri_r;
      gnt1_s = pri_r;
    end else begin
      gnt0_s = i_p0_req;
      gnt1_s = i_p1_req;
    end
  end

  assign o_p0_gnt = gnt0_s;
  assign o_p1_gnt = gnt1_s;

  // Shared memory drive: only the granted, legal access touches the memory.
  always_comb begin
    o_mem_addr  = {AW{1'b0}};
    o_mem_bmask = 4'b0000;
    o_mem_wdata = 32'h0000_0000;
    o_mem_wren  = 1'b0;
    if (gnt0_s) begin
      o_mem_addr  = i_p0_addr;
      o_mem_bmask = 4'b1111;
      o_mem_wdata = 32'h0000_0000;
      o_mem_wren  = 1'b0;
    end else if (gnt1_s && !p1_err_s) begin
      o_mem_addr  = i_p1_addr;
      o_mem_bmask = size_mask(i_p1_size);
      o_mem_wdata = i_p1_wdata;
      o_mem_wren  = i_p1_wren;
    end else begin
      o_mem_addr  = {AW{1'b0}};
      o_mem_bmask = 4'b0000;
      o_mem_wdata = 32'h0000_0000;
      o_mem_wren  = 1'b0;
    end
  end

  // Port 1 response word: stores and faulting accesses report zero data.
  always_comb begin
    p1_resp_s = 32'h0000_0000;
    if (p1_err_s || i_p1_wren) begin
      p1_resp_s = 32'h0000_0000;
    end else begin
      p1_resp_s = load_extend(i_p1_size, i_p1_unsigned, i_mem_rdata);
    end
  end

  // Priority register: after each grant the other port gets priority.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pri_r <= 1'b1;
    end else if (gnt0_s) begin
      pri_r <= 1'b1;
    end else if (gnt1_s) begin
      pri_r <= 1'b0;
    end else begin
      pri_r <= pri_r;
    end
  end

  // Response capture at the grant edge; rdata holds between responses.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      p0_rvalid_r <= 1'b0;
      p0_rdata_r  <= 32'h0000_0000;
      p1_rvalid_r <= 1'b0;
      p1_err_r    <= 1'b0;
      p1_rdata_r  <= 32'h0000_0000;
    end else begin
      p0_rvalid_r <= gnt0_s;
      p1_rvalid_r <= gnt1_s;
      p1_err_r    <= gnt1_s & p1_err_s;
      if (gnt0_s) begin
        p0_rdata_r <= i_mem_rdata;
      end else begin
        p0_rdata_r <= p0_rdata_r;
      end
      if (gnt1_s) begin
        p1_rdata_r <= p1_resp_s;
      end else begin
        p1_rdata_r <= p1_rdata_r;
      end
    end
  end

  // A response captured just before reset rises is still in the registers
  // during the reset cycle; masking with i_reset keeps it from being seen.
  assign o_p0_rvalid = p0_rvalid_r & ~i_reset;
  assign o_p0_rdata  = i_reset ? 32'h0000_0000 : p0_rdata_r;
  assign o_p1_rvalid = p1_rvalid_r & ~i_reset;
  assign o_p1_err    = p1_err_r & ~i_reset;
  assign o_p1_rdata  = i_reset ? 32'h0000_0000 : p1_rdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed stimulus, byte-array memory model and
// response scoreboard (expected responses queued at grant, checked at rvalid).
module tb_mem_arbiter;

  localparam int AW = 8;

  logic          clk;
  logic          rst;
  logic          p0_req;
  logic [AW-1:0] p0_addr;
  logic          p0_gnt;
  logic          p0_rvalid;
  logic [31:0]   p0_rdata;
  logic          p1_req;
  logic [AW-1:0] p1_addr;
  logic          p1_wren;
  logic [1:0]    p1_size;
  logic          p1_uns;
  logic [31:0]   p1_wdata;
  logic          p1_gnt;
  logic          p1_rvalid;
  logic [31:0]   p1_rdata;
  logic          p1_err;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_bmask;
  logic [31:0]   mem_wdata;
  logic          mem_wren;
  logic [31:0]   mem_rdata;

  logic [7:0] mem [0:255];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  logic [31:0] q0 [$];
  resp_t       q1 [$];

  int          tests = 0;
  int          fails = 0;
  logic        tb_pri = 1'b1;
  logic [31:0] last0 = 32'h0;
  logic [31:0] last1 = 32'h0;
  logic        obs_g0;
  logic        obs_g1;
  logic        lit_en = 1'b0;
  logic [31:0] lit = 32'h0;

  mem_arbiter #(.AW(AW)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_p0_req     (p0_req),
    .i_p0_addr    (p0_addr),
    .o_p0_gnt     (p0_gnt),
    .o_p0_rvalid  (p0_rvalid),
    .o_p0_rdata   (p0_rdata),
    .i_p1_req     (p1_req),
    .i_p1_addr    (p1_addr),
    .i_p1_wren    (p1_wren),
    .i_p1_size    (p1_size),
    .i_p1_unsigned(p1_uns),
    .i_p1_wdata   (p1_wdata),
    .o_p1_gnt     (p1_gnt),
    .o_p1_rvalid  (p1_rvalid),
    .o_p1_rdata   (p1_rdata),
    .o_p1_err     (p1_err),
    .o_mem_addr   (mem_addr),
    .o_mem_bmask  (mem_bmask),
    .o_mem_wdata  (mem_wdata),
    .o_mem_wren   (mem_wren),
    .i_mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational little-endian memory read.
  assign mem_rdata = {mem[mem_addr + 8'd3], mem[mem_addr + 8'd2],
                      mem[mem_addr + 8'd1], mem[mem_addr]};

  function automatic logic [31:0] rd_word(input logic [7:0] a);
    return {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check responses and grants at negedge, queue new
  // expectations, then perform the memory write on the rising edge.
  task automatic cycle();
    logic        eg0, eg1, perr;
    logic [3:0]  ebm;
    logic [31:0] word, ext, resp;
    logic        w_en;
    logic [3:0]  w_bm;
    logic [7:0]  w_a;
    logic [31:0] w_d;
    resp_t       e;
    @(negedge clk);
    if (rst) begin
      chk("rst_rvalid0", p0_rvalid, 1'b0);
      chk("rst_rvalid1", p1_rvalid, 1'b0);
      chk("rst_err1", p1_err, 1'b0);
      q0.delete();
      q1.delete();
      last0 = 32'h0;
      last1 = 32'h0;
    end else begin
      chk("rvalid0", p0_rvalid, (q0.size() != 0));
      if (q0.size() != 0) last0 = q0.pop_front();
      chk("rdata0", p0_rdata, last0);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        last1 = e.rdata;
        chk("rvalid1", p1_rvalid, 1'b1);
        chk("err1", p1_err, e.err);
      end else begin
        chk("rvalid1", p1_rvalid, 1'b0);
        chk("err1", p1_err, 1'b0);
      end
      chk("rdata1", p1_rdata, last1);
    end

    eg0 = !rst && p0_req && (!p1_req || !tb_pri);
    eg1 = !rst && p1_req && (!p0_req || tb_pri);
    obs_g0 = p0_gnt;
    obs_g1 = p1_gnt;
    chk("gnt0", p0_gnt, eg0);
    chk("gnt1", p1_gnt, eg1);

    perr = (p1_size == 2'b11) || (p1_size == 2'b10 && p1_addr[1:0] != 2'b00) ||
           (p1_size == 2'b01 && p1_addr[0]);
    case (p1_size)
      2'b00:   ebm = 4'b0001;
      2'b01:   ebm = 4'b0011;
      default: ebm = 4'b1111;
    endcase

    if (eg0) begin
      chk("mem_addr_p0", mem_addr, p0_addr);
      chk("mem_bmask_p0", mem_bmask, 4'b1111);
      chk("mem_wren_p0", mem_wren, 1'b0);
    end else if (eg1 && !perr) begin
      chk("mem_addr_p1", mem_addr, p1_addr);
      chk("mem_bmask_p1", mem_bmask, ebm);
      chk("mem_wren_p1", mem_wren, p1_wren);
      chk("mem_wdata_p1", mem_wdata, p1_wdata);
    end else begin
      chk("mem_addr_idle", mem_addr, 8'h00);
      chk("mem_bmask_idle", mem_bmask, 4'b0000);
      chk("mem_wren_idle", mem_wren, 1'b0);
      chk("mem_wdata_idle", mem_wdata, 32'h0);
    end

    if (eg0) q0.push_back(rd_word(p0_addr));
    if (eg1) begin
      word = rd_word(p1_addr);
      case (p1_size)
        2'b00:   ext = p1_uns ? {24'h0, word[7:0]} : {{24{word[7]}}, word[7:0]};
        2'b01:   ext = p1_uns ? {16'h0, word[15:0]} : {{16{word[15]}}, word[15:0]};
        default: ext = word;
      endcase
      resp = (perr || p1_wren) ? 32'h0 : ext;
      if (lit_en) begin
        resp = lit;
        lit_en = 1'b0;
      end
      e.rdata = resp;
      e.err   = perr;
      q1.push_back(e);
    end

    w_en = mem_wren;
    w_bm = mem_bmask;
    w_a  = mem_addr;
    w_d  = mem_wdata;
    @(posedge clk);
    if (rst) tb_pri = 1'b1;
    else if (eg0) tb_pri = 1'b1;
    else if (eg1) tb_pri = 1'b0;
    #1;
    if (w_en) begin
      for (int k = 0; k < 4; k++) begin
        if (w_bm[k]) mem[w_a + 8'(k)] = w_d[8*k +: 8];
      end
    end
  endtask

  task automatic p1_set(input logic [7:0] a, input logic [1:0] sz, input logic we,
                        input logic uns, input logic [31:0] wd);
    p1_req = 1'b1; p1_addr = a; p1_size = sz; p1_wren = we; p1_uns = uns; p1_wdata = wd;
  endtask

  logic [5:0]  pat;
  logic [31:0] saved;
  logic [7:0]  addrs [4];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 5 + 3);
    mem[16] = 8'h11; mem[17] = 8'h22; mem[18] = 8'h33; mem[19] = 8'h44;
    rst = 1'b1;
    p0_req = 1'b0; p0_addr = 8'h00;
    p1_req = 1'b0; p1_addr = 8'h00; p1_size = 2'b10; p1_wren = 1'b0;
    p1_uns = 1'b0; p1_wdata = 32'h0;
    repeat (2) cycle();

    // Both ports request while in reset: no grant, memory idle.
    p0_req = 1'b1; p0_addr = 8'h20;
    p1_set(8'h10, 2'b10, 1'b0, 1'b0, 32'hDEADBEEF);
    cycle();

    // Release: p1 wins first (pri=1), then p0.
    rst = 1'b0;
    lit_en = 1'b1; lit = 32'h44332211;
    cycle(); chk("first_g1", obs_g1, 1'b1);
    p1_req = 1'b0;
    cycle(); chk("second_g0", obs_g0, 1'b1);
    p0_req = 1'b0;
    cycle();

    // Continuous contention alternates p1,p0,p1,p0,p1,p0.
    p0_req = 1'b1; p0_addr = 8'h08;
    p1_set(8'h0C, 2'b10, 1'b0, 1'b0, 32'h0);
    pat = 6'b101010;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("alt_g1", obs_g1, pat[5 - i]);
    end
    p0_req = 1'b0; p1_req = 1'b0;
    cycle();

    // Byte store, then signed and unsigned byte loads.
    p1_set(8'h05, 2'b00, 1'b1, 1'b0, 32'hAABBCC80);
    cycle();
    p1_set(8'h05, 2'b00, 1'b0, 1'b0, 32'h0);
    lit_en = 1'b1; lit = 32'hFFFFFF80;
    cycle();
    p1_set(8'h05, 2'b00, 1'b0, 1'b1, 32'h0);
    lit_en = 1'b1; lit = 32'h00000080;
    cycle();

    // Half store/load with sign bit set, word store/load round trip.
    p1_set(8'h0A, 2'b01, 1'b1, 1'b0, 32'h12348123);
    cycle();
    p1_set(8'h0A, 2'b01, 1'b0, 1'b0, 32'h0);
    lit_en = 1'b1; lit = 32'hFFFF8123;
    cycle();
    p1_set(8'h20, 2'b10, 1'b1, 1'b0, 32'hCAFEF00D);
    cycle();
    p1_set(8'h20, 2'b10, 1'b0, 1'b0, 32'h0);
    lit_en = 1'b1; lit = 32'hCAFEF00D;
    cycle();

    // Misaligned and illegal accesses: flagged, memory untouched.
    saved = {mem[9], mem[8], mem[7], mem[6]};
    p1_set(8'h03, 2'b01, 1'b0, 1'b0, 32'h0);
    cycle();
    p1_set(8'h06, 2'b10, 1'b1, 1'b0, 32'h55555555);
    cycle();
    p1_set(8'h08, 2'b11, 1'b1, 1'b0, 32'h66666666);
    cycle();
    p1_req = 1'b0;
    repeat (2) cycle();
    chk("err_mem_unchanged", {mem[9], mem[8], mem[7], mem[6]}, saved);

    // Grant immediately followed by reset: the response is discarded.
    p0_req = 1'b1; p0_addr = 8'h04;
    cycle(); chk("pre_rst_g0", obs_g0, 1'b1);
    p0_req = 1'b0; rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    p0_req = 1'b1; p0_addr = 8'h00;
    p1_set(8'h10, 2'b10, 1'b0, 1'b0, 32'h0);
    cycle(); chk("post_rst_pri", obs_g1, 1'b1);
    p1_req = 1'b0;
    cycle();
    p0_req = 1'b0;
    cycle();

    // Back-to-back port 0 fetches.
    addrs[0] = 8'h00; addrs[1] = 8'h04; addrs[2] = 8'h08; addrs[3] = 8'h0C;
    p0_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      p0_addr = addrs[i];
      cycle();
      chk("stream_g0", obs_g0, 1'b1);
    end
    p0_req = 1'b0;
    repeat (2) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
